// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature step decoder: phase states, direction
// values and the transition classifier used by the decode logic.
package quad_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_UP,
    EV_DOWN,
    EV_ERR
  } quad_event_e;

  // Successor of a phase state along the up sequence 00->10->11->01->00.
  function automatic logic [1:0] up_next(input logic [1:0] ph);
    case (ph)
      PH_00:   return PH_10;
      PH_10:   return PH_11;
      PH_11:   return PH_01;
      default: return PH_00;
    endcase
  endfunction

  function automatic quad_event_e classify(input logic [1:0] prev, input logic [1:0] cur);
    if (cur == prev)          return EV_NONE;
    if (cur == up_next(prev)) return EV_UP;
    if (prev == up_next(cur)) return EV_DOWN;
    return EV_ERR;
  endfunction

endpackage

// File: rtl/quad_sync.sv
// SYNC_STAGES-deep synchronizer for the A/B pair, with a companion valid chain
// that marks when the output reflects a sample taken after reset release.
module quad_sync
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] d,
  output logic [1:0] q,
  output logic       valid
);

  logic [SYNC_STAGES-1:0][1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0]      valid_q, valid_d;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], d};
    valid_d = {valid_q[SYNC_STAGES-2:0], 1'b1};
  end

  // NOTE: flops use non-blocking assignments so every stage samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      valid_q <= '0;
    end else begin
      sync_q  <= sync_d;
      valid_q <= valid_d;
    end
  end

  assign q     = sync_q[SYNC_STAGES-1];
  assign valid = valid_q[SYNC_STAGES-1];

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature A/B decoder: recovers step/direction events and drives a
// wrap-around up/down position counter with a sticky illegal-transition flag.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             A,
  input  logic             B,
  input  logic             Clear,
  output logic [WIDTH-1:0] Count,
  output logic             Step,
  output logic             UpOrDown,
  output logic             ErrFlag
);

  logic [1:0] cur;
  logic       cur_valid;

  quad_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (Clk),
    .rst_n (reset),
    .d     ({A, B}),
    .q     (cur),
    .valid (cur_valid)
  );

  logic [1:0]       prev_q, prev_d;
  logic             primed_q, primed_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  quad_event_e      ev;

  // Priming waits for cur_valid so the zeroed synchronizer contents never
  // get compared against the first real input level after reset release.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no branch
    // can leave a value unassigned and infer a latch.
    prev_d   = prev_q;
    primed_d = primed_q;
    count_d  = count_q;
    step_d   = 1'b0;
    dir_d    = dir_q;
    err_d    = err_q;
    ev       = classify(prev_q, cur);

    if (cur_valid) begin
      prev_d = cur;
      if (!primed_q) begin
        primed_d = 1'b1;
      end else begin
        case (ev)
          EV_UP: begin
            step_d  = 1'b1;
            dir_d   = DIR_UP;
            count_d = count_q + WIDTH'(1);
          end
          EV_DOWN: begin
            step_d  = 1'b1;
            dir_d   = DIR_DOWN;
            count_d = count_q - WIDTH'(1);
          end
          EV_ERR:  err_d = 1'b1;
          default: ;
        endcase
      end
    end

    // Clear wins over a same-edge step or error; Step/UpOrDown still report it.
    if (Clear) begin
      count_d = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      prev_q   <= PH_00;
      primed_q <= 1'b0;
      count_q  <= '0;
      step_q   <= 1'b0;
      dir_q    <= DIR_UP;
      err_q    <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      primed_q <= primed_d;
      count_q  <= count_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
    end
  end

  assign Count    = count_q;
  assign Step     = step_q;
  assign UpOrDown = dir_q;
  assign ErrFlag  = err_q;

endmodule
